// File: rtl/ledger_validator.sv
// ledger_validator
// Validates one transfer request at a time against an internal ledger RAM.
// Sender and receiver accounts are resolved by a linear scan of the live
// entries. Missing accounts are allocated with INIT_BAL. A legal transfer is
// written back. The request is then returned with a status code over a
// valid/ready handshake.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous, active-high reset
//   data_i    {sender, receiver, amount/pad [31:10], block_start [9], passthrough [8:0]}
//   valid_i   request present
//   ack_o     one-cycle pulse: request captured this cycle
//   data_o    captured request, unmodified
//   status_o  0 OK, 1 NOFUNDS, 2 OVERFLOW, 3 FULL, 4 SELF
//   valid_o   result present, held until taken
//   ready_i   downstream accepts the result
//   count_o   number of allocated ledger entries
module ledger_validator #(
  parameter int ID_W     = 48,
  parameter int AMT_W    = 22,
  parameter int BAL_W    = 24,
  parameter int DEPTH    = 16384,
  parameter int MAX_SCAN = 3000,
  parameter int INIT_BAL = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*ID_W+31:0]      data_i,
  input  logic                    valid_i,
  output logic                    ack_o,
  output logic [2*ID_W+31:0]      data_o,
  output logic [2:0]              status_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int DW = 2*ID_W + 32;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + BAL_W;

  localparam logic [2:0] STAT_OK       = 3'd0;
  localparam logic [2:0] STAT_NOFUNDS  = 3'd1;
  localparam logic [2:0] STAT_OVERFLOW = 3'd2;
  localparam logic [2:0] STAT_FULL     = 3'd3;
  localparam logic [2:0] STAT_SELF     = 3'd4;

  typedef enum logic [2:0] {
    IDLE, SCAN_ISSUE, SCAN, ALLOC, CHECK, WR_SND, WR_RCV, OUT
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [DW-1:0]    data_r, data_nxt_s;
  logic [2:0]       status_r, status_nxt_s;
  logic             valid_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [CW-1:0]    idx_r, idx_nxt_s, idx_inc_s, need_s;
  logic             snd_found_r, snd_found_nxt_s;
  logic             rcv_found_r, rcv_found_nxt_s;
  logic             rej_r, rej_nxt_s;
  logic [AW-1:0]    snd_ptr_r, snd_ptr_nxt_s, rcv_ptr_r, rcv_ptr_nxt_s;
  logic [BAL_W-1:0] snd_bal_r, snd_bal_nxt_s, rcv_bal_r, rcv_bal_nxt_s;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_data_r;
  logic [AW-1:0]    rd_addr_s, wr_addr_s;
  logic [EW-1:0]    wr_data_s;
  logic             we_s;
  logic             ack_s;

  logic [ID_W-1:0]  snd_id_s, rcv_id_s, ent_id_s;
  logic [BAL_W-1:0] amt_ext_s, ent_bal_s;
  logic [BAL_W:0]   sum_s;
  logic             in_range_s, hit_snd_s, hit_rcv_s, both_s, scan_last_s;
  logic             full_s, self_s, nofunds_s;

  assign snd_id_s  = data_r[DW-1 -: ID_W];
  assign rcv_id_s  = data_r[ID_W+31 -: ID_W];
  assign amt_ext_s = BAL_W'(data_r[31 -: AMT_W]);
  assign ent_id_s  = rd_data_r[EW-1 -: ID_W];
  assign ent_bal_s = rd_data_r[BAL_W-1:0];

  // rd_data_r always holds entry idx_r while scanning; only live entries count.
  assign idx_inc_s   = idx_r + CW'(1);
  assign in_range_s  = (idx_r < count_r);
  assign hit_snd_s   = in_range_s && (ent_id_s == snd_id_s);
  assign hit_rcv_s   = in_range_s && (ent_id_s == rcv_id_s);
  assign both_s      = (snd_found_r | hit_snd_s) & (rcv_found_r | hit_rcv_s);
  assign scan_last_s = (idx_inc_s == count_r) || (idx_inc_s == CW'(MAX_SCAN));

  assign need_s    = CW'(!snd_found_r) + CW'(!rcv_found_r);
  assign full_s    = ({1'b0, count_r} + {1'b0, need_s}) > (CW+1)'(DEPTH);
  assign self_s    = (snd_id_s == rcv_id_s);
  assign nofunds_s = (snd_bal_r < amt_ext_s);
  // One extra bit so receiver overflow is visible as the carry out.
  assign sum_s     = {1'b0, rcv_bal_r} + {1'b0, amt_ext_s};

  assign ack_o    = ack_s & ~rst;
  assign data_o   = data_r;
  assign status_o = status_r;
  assign valid_o  = valid_r;
  assign count_o  = count_r;

  // Ledger RAM: one write port, registered read with one cycle latency.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
    rd_data_r <= mem[rd_addr_s];
  end

  // Next-state, datapath updates and RAM control for the request sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    data_nxt_s      = data_r;
    status_nxt_s    = status_r;
    count_nxt_s     = count_r;
    idx_nxt_s       = idx_r;
    snd_found_nxt_s = snd_found_r;
    rcv_found_nxt_s = rcv_found_r;
    rej_nxt_s       = rej_r;
    snd_ptr_nxt_s   = snd_ptr_r;
    rcv_ptr_nxt_s   = rcv_ptr_r;
    snd_bal_nxt_s   = snd_bal_r;
    rcv_bal_nxt_s   = rcv_bal_r;
    rd_addr_s       = '0;
    wr_addr_s       = '0;
    wr_data_s       = '0;
    we_s            = 1'b0;
    ack_s           = 1'b0;

    case (state_r)
      IDLE: begin
        if (valid_i) begin
          ack_s           = 1'b1;
          data_nxt_s      = data_i;
          // block_start discards every account before the scan begins.
          count_nxt_s     = data_i[9] ? '0 : count_r;
          idx_nxt_s       = '0;
          snd_found_nxt_s = 1'b0;
          rcv_found_nxt_s = 1'b0;
          rej_nxt_s       = 1'b0;
          state_nxt_s     = SCAN_ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SCAN_ISSUE: begin
        rd_addr_s   = '0;
        state_nxt_s = SCAN;
      end

      SCAN: begin
        rd_addr_s = AW'(idx_inc_s);
        idx_nxt_s = idx_inc_s;
        // Later matches overwrite earlier ones: last match wins.
        if (hit_snd_s) begin
          snd_found_nxt_s = 1'b1;
          snd_ptr_nxt_s   = AW'(idx_r);
          snd_bal_nxt_s   = ent_bal_s;
        end else begin
          snd_found_nxt_s = snd_found_r;
        end
        if (hit_rcv_s) begin
          rcv_found_nxt_s = 1'b1;
          rcv_ptr_nxt_s   = AW'(idx_r);
          rcv_bal_nxt_s   = ent_bal_s;
        end else begin
          rcv_found_nxt_s = rcv_found_r;
        end
        if (!in_range_s || both_s || scan_last_s) begin
          state_nxt_s = ALLOC;
        end else begin
          state_nxt_s = SCAN;
        end
      end

      ALLOC: begin
        state_nxt_s = CHECK;
        if (self_s) begin
          status_nxt_s = STAT_SELF;
          rej_nxt_s    = 1'b1;
        end else if (full_s) begin
          status_nxt_s = STAT_FULL;
          rej_nxt_s    = 1'b1;
        end else begin
          // New accounts take the next free slots, sender first.
          if (!snd_found_r) begin
            snd_ptr_nxt_s = AW'(count_r);
            snd_bal_nxt_s = BAL_W'(INIT_BAL);
          end else begin
            snd_ptr_nxt_s = snd_ptr_r;
          end
          if (!rcv_found_r) begin
            rcv_ptr_nxt_s = AW'(count_r + CW'(!snd_found_r));
            rcv_bal_nxt_s = BAL_W'(INIT_BAL);
          end else begin
            rcv_ptr_nxt_s = rcv_ptr_r;
          end
          count_nxt_s = count_r + need_s;
        end
      end

      CHECK: begin
        if (rej_r) begin
          state_nxt_s = OUT;
        end else if (nofunds_s) begin
          status_nxt_s = STAT_NOFUNDS;
          state_nxt_s  = OUT;
        end else if (sum_s[BAL_W]) begin
          status_nxt_s = STAT_OVERFLOW;
          state_nxt_s  = OUT;
        end else begin
          status_nxt_s  = STAT_OK;
          snd_bal_nxt_s = snd_bal_r - amt_ext_s;
          rcv_bal_nxt_s = sum_s[BAL_W-1:0];
          state_nxt_s   = WR_SND;
        end
      end

      WR_SND: begin
        we_s        = 1'b1;
        wr_addr_s   = snd_ptr_r;
        wr_data_s   = {snd_id_s, snd_bal_r};
        state_nxt_s = WR_RCV;
      end

      WR_RCV: begin
        we_s        = 1'b1;
        wr_addr_s   = rcv_ptr_r;
        wr_data_s   = {rcv_id_s, rcv_bal_r};
        state_nxt_s = OUT;
      end

      OUT: begin
        if (ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers; valid_o is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= '0;
      status_r    <= 3'd0;
      valid_r     <= 1'b0;
      count_r     <= '0;
      idx_r       <= '0;
      snd_found_r <= 1'b0;
      rcv_found_r <= 1'b0;
      rej_r       <= 1'b0;
      snd_ptr_r   <= '0;
      rcv_ptr_r   <= '0;
      snd_bal_r   <= '0;
      rcv_bal_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      data_r      <= data_nxt_s;
      status_r    <= status_nxt_s;
      valid_r     <= (state_nxt_s == OUT);
      count_r     <= count_nxt_s;
      idx_r       <= idx_nxt_s;
      snd_found_r <= snd_found_nxt_s;
      rcv_found_r <= rcv_found_nxt_s;
      rej_r       <= rej_nxt_s;
      snd_ptr_r   <= snd_ptr_nxt_s;
      rcv_ptr_r   <= rcv_ptr_nxt_s;
      snd_bal_r   <= snd_bal_nxt_s;
      rcv_bal_r   <= rcv_bal_nxt_s;
    end
  end

endmodule

// File: doc/ledger_validator.md
# ledger_validator

Parametrised successor to the single-channel transaction validator. It accepts one transfer request at a time, resolves the sender and receiver accounts in an internal ledger RAM by linear scan, and allocates new accounts with an initial balance. It applies the transfer if it is legal and returns the request with a status code over a valid/ready output handshake. It sits between the transaction decoder and the block packer and supports back-pressure.

## Interface
- ID_W, 48: account ID width.
- AMT_W, 22: amount width, 1..22; field occupies data_i[31:32-AMT_W].
- BAL_W, 24: balance width, ≥ AMT_W.
- DEPTH, 16384: ledger entries, power of two.
- MAX_SCAN, 3000: maximum entries examined per request, 1..DEPTH.
- INIT_BAL, 100: balance given to a newly allocated account.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  2*ID_W+32  {sender, receiver, amount/pad [31:10], block_start [9], passthrough [8:0]}.
- valid_i  in  1  request present.
- ack_o  out  1  one-cycle pulse: request captured.
- data_o  out  2*ID_W+32  captured request, unmodified.
- status_o  out  3  0 OK, 1 NOFUNDS, 2 OVERFLOW, 3 FULL, 4 SELF.
- valid_o  out  1  result present; held until taken.
- ready_i  in  1  downstream accepts result.
- count_o  out  $clog2(DEPTH)+1  allocated ledger entries.

## Operation
- Ledger entry layout: {id[ID_W], balance[BAL_W]}.
- Entries 0..count-1 are live. The RAM has 1-cycle registered read latency and one write port.
- States: IDLE, SCAN_ISSUE, SCAN, ALLOC, CHECK, WR_SND, WR_RCV, OUT.
- IDLE: when valid_i=1, pulse ack_o and capture data_i. If block_start=1, count is set to 0 before the scan, so all prior accounts are discarded. Go to SCAN_ISSUE.
- SCAN_ISSUE: issue read of address 0.
- SCAN: examine one entry per cycle and record the pointer and balance on an ID match.
  - If multiple entries match, the last match wins.
  - Terminate when both accounts are found, the index reaches count, or the index reaches MAX_SCAN.
  - An account not found within MAX_SCAN is treated as new. A duplicate entry is the accepted consequence.
- ALLOC: compute `need` = number of unfound accounts.
  - If sender == receiver: status SELF, no allocation.
  - Else if count + need > DEPTH: status FULL, no allocation.
  - Else assign pointers count, count+1 (sender first), set their balances to INIT_BAL, and count += need.
- CHECK: status priority is SELF > FULL > NOFUNDS > OVERFLOW > OK.
  - NOFUNDS if sender_bal < amount.
  - OVERFLOW if receiver_bal + amount > 2^BAL_W−1, computed at BAL_W+1 bits.
  - On OK: sender_bal −= amount, receiver_bal += amount, go to WR_SND. Otherwise go to OUT.
  - Allocations made in ALLOC persist even if the transfer is rejected.
- WR_SND, WR_RCV: write {id, balance} to the sender pointer, then to the receiver pointer.
- OUT: valid_o=1, data_o/status_o stable. Leave to IDLE on ready_i=1.
- amount = 0 is legal: status OK, balances unchanged, writes still performed.

## Timing
- Reset values: ack_o=0, valid_o=0, data_o=0, status_o=0, count_o=0, state IDLE, RAM write enable 0. RAM contents are not cleared; count=0 makes them dead.
- Reset mid-operation: state returns to IDLE next cycle and the in-flight request is lost. A write in progress in WR_SND/WR_RCV may complete to the RAM; it is harmless because count=0.
- Let ack_o be high in cycle t, and let M = max(K,1), where K is the number of entries examined.
  - Accepted: valid_o first high at t+6+M.
  - Rejected: valid_o first high at t+4+M.
- Worst-case M = MAX_SCAN.
- ack_o never asserts outside IDLE. A new request may be acked in the cycle after the OUT handshake. No read/write overlap, so no forwarding is needed.
- valid_o, data_o and status_o hold while ready_i=0. ready_i is ignored when valid_o=0.
- count_o updates at the end of ALLOC, or at capture when block_start=1.

## Test plan
- Reset, then block_start=1, A→B amount 30.
  - Required: count_o=2, OK, valid_o at t+7.
  - Ledger holds A=70, B=130.
- Follow with B→A amount 131.
  - Required: NOFUNDS, balances unchanged, valid_o at t+4+2.
- DEPTH=4 build, block_start request A→B, then C→D, then E→F.
  - Required: third request returns FULL and count_o stays 4.
- BAL_W=8, INIT_BAL=250 build: A→B amount 10.
  - Required: OVERFLOW (250+10>255), count_o=2.
  - Then A→A amount 1 returns SELF.
- Hold ready_i=0 for 20 cycles during OUT.
  - Required: valid_o, data_o and status_o constant, no ack_o despite valid_i=1.
  - Release ready_i: ack_o follows next cycle.
- Assert rst during SCAN of a 100-entry ledger.
  - Required: all outputs 0 the next cycle.
  - A following non-block_start request X→Y allocates at 0,1 with OK.
